// File: rtl/vga_timing_ctrl_if.sv
// Pixel-side bus of the VGA timing controller: scan coordinates out, colour back in, pins out.
// Optional test_pattern input exists only when VGA_COLORBAR_EN is defined.
interface vga_timing_ctrl_if;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        frame_start;
    logic [23:0] pos_data;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [23:0] rgb;
`ifdef VGA_COLORBAR_EN
    logic        test_pattern;
`endif

    modport master (
        output pos_x, pos_y, frame_start, hsync, vsync, de, rgb,
`ifdef VGA_COLORBAR_EN
        input  test_pattern,
`endif
        input  pos_data
    );

    modport slave (
        input  pos_x, pos_y, frame_start, hsync, vsync, de, rgb,
`ifdef VGA_COLORBAR_EN
        output test_pattern,
`endif
        output pos_data
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Raster counters, sync generation and aligned pixel output stage for the VGA path.
// Define VGA_COLORBAR_EN to add the test_pattern colour-bar source.
module vga_timing_ctrl #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned PIPE_LAT  = 1
) (
    input  logic               vga_clk,
    input  logic               rst,
    vga_timing_ctrl_if.master  vga
);
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;
    logic       hs_raw;
    logic       vs_raw;

    logic [PIPE_LAT-1:0] active_sr;
    logic [PIPE_LAT-1:0] hs_sr;
    logic [PIPE_LAT-1:0] vs_sr;
    logic                active_d;
    logic                hs_d;
    logic                vs_d;
    logic [23:0]         pix_src;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_comb begin
        active = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
        hs_raw = !((h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END)));
        vs_raw = !((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END)));
    end

    // All-ones coordinates make downstream window tests fail during blanking.
    assign vga.pos_x       = active ? h_cnt : 10'h3FF;
    assign vga.pos_y       = active ? v_cnt : 10'h3FF;
    assign vga.frame_start = (h_cnt == '0) && (v_cnt == '0);

    assign active_d = active_sr[PIPE_LAT-1];
    assign hs_d     = hs_sr[PIPE_LAT-1];
    assign vs_d     = vs_sr[PIPE_LAT-1];

`ifdef VGA_COLORBAR_EN
    localparam int unsigned COL_W = PIPE_LAT * 10;
    localparam int unsigned BAR_W = H_VISIBLE / 8;

    logic [PIPE_LAT-1:0][9:0] col_sr;
    logic [9:0]               col_d;
    logic [2:0]               bar_idx;
    logic [23:0]              bar_rgb;

    always_ff @(posedge vga_clk) begin
        if (rst) col_sr <= '0;
        else     col_sr <= COL_W'({col_sr, h_cnt});
    end

    assign col_d   = col_sr[PIPE_LAT-1];
    assign bar_idx = 3'(col_d / 10'(BAR_W));

    always_comb begin
        bar_rgb = '0;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    assign pix_src = vga.test_pattern ? bar_rgb : vga.pos_data;
`else
    assign pix_src = vga.pos_data;
`endif

    // Shift registers take the new sample in bit 0; the cast drops the oldest bit.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            active_sr <= '0;
            hs_sr     <= '1;
            vs_sr     <= '1;
            vga.de    <= 1'b0;
            vga.hsync <= 1'b1;
            vga.vsync <= 1'b1;
            vga.rgb   <= '0;
        end else begin
            active_sr <= PIPE_LAT'({active_sr, active});
            hs_sr     <= PIPE_LAT'({hs_sr, hs_raw});
            vs_sr     <= PIPE_LAT'({vs_sr, vs_raw});
            vga.de    <= active_d;
            vga.hsync <= hs_d;
            vga.vsync <= vs_d;
            vga.rgb   <= active_d ? pix_src : '0;
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default 640x480 instance and a shrunken-timing instance
// checked every cycle against an arithmetic raster model, plus hand vectors and corner sequences.
module tb_vga_timing_ctrl;
    localparam int D_HV = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VV = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
    localparam int S_HV = 16,  S_HF = 2,  S_HS = 3,  S_HB = 3;
    localparam int S_VV = 8,   S_VF = 2,  S_VS = 2,  S_VB = 3;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_FRAME = S_HT * (S_VV + S_VF + S_VS + S_VB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    vga_timing_ctrl_if vd ();
    vga_timing_ctrl_if vs_if ();

    vga_timing_ctrl u_def (
        .vga_clk (clk),
        .rst     (rst),
        .vga     (vd)
    );

    vga_timing_ctrl #(
        .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .PIPE_LAT  (1)
    ) u_small (
        .vga_clk (clk),
        .rst     (rst),
        .vga     (vs_if)
    );

    bit tp = 1'b0;
    bit tp_last = 1'b0;
`ifdef VGA_COLORBAR_EN
    assign vd.test_pattern    = tp;
    assign vs_if.test_pattern = tp;
`endif

    typedef struct packed {
        logic [9:0]  px;
        logic [9:0]  py;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } obs_t;

    typedef struct {
        int          t;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        fs;
        logic        de;
        logic        hs;
        logic [23:0] rgb;
    } vec_t;

    int total = 0;
    int bad = 0;
    int t = 0;
    bit echo = 1'b1;
    obs_t obs [2];
    logic [9:0] px_prev [2];
    logic [9:0] py_prev [2];
    logic [23:0] pd_last [2];
    int hs_run = 0, hs_start = 0;
    int fr_cyc = 0, fr_de = 0, fr_vs = 0;
    bit fr_valid = 1'b0;

    function automatic logic [23:0] bar_color(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected pins at cycle tt after the last reset edge; pins lag counters by two clocks.
    function automatic obs_t model(input int k, input int tt, input logic [23:0] pd, input bit tpat);
        int hv, hf, hsw, hb, vv, vf, vsw, vb, ht, vt, h, v, u, hu, vu;
        bit act;
        obs_t m;
        if (k == 0) begin
            hv = D_HV; hf = D_HF; hsw = D_HS; hb = D_HB; vv = D_VV; vf = D_VF; vsw = D_VS; vb = D_VB;
        end else begin
            hv = S_HV; hf = S_HF; hsw = S_HS; hb = S_HB; vv = S_VV; vf = S_VF; vsw = S_VS; vb = S_VB;
        end
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        h = tt % ht;
        v = (tt / ht) % vt;
        act = (h < hv) && (v < vv);
        m.px = act ? 10'(h) : 10'h3FF;
        m.py = act ? 10'(v) : 10'h3FF;
        m.fs = (h == 0) && (v == 0);
        if (tt < 2) begin
            m.hs = 1'b1; m.vs = 1'b1; m.de = 1'b0; m.rgb = 24'h0;
        end else begin
            u = tt - 2;
            hu = u % ht;
            vu = (u / ht) % vt;
            act = (hu < hv) && (vu < vv);
            m.hs = !((hu >= hv + hf) && (hu < hv + hf + hsw));
            m.vs = !((vu >= vv + vf) && (vu < vv + vf + vsw));
            m.de = act;
            m.rgb = !act ? 24'h0 : (tpat ? bar_color(hu / (hv / 8)) : pd);
        end
        return m;
    endfunction

    task automatic hchk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
        end
    endtask

    task automatic sample();
        obs_t e;
        @(negedge clk);
        obs[0] = {vd.pos_x, vd.pos_y, vd.frame_start, vd.hsync, vd.vsync, vd.de, vd.rgb};
        obs[1] = {vs_if.pos_x, vs_if.pos_y, vs_if.frame_start, vs_if.hsync, vs_if.vsync, vs_if.de, vs_if.rgb};
        for (int k = 0; k < 2; k++) begin
            e = model(k, t, pd_last[k], tp_last);
            total++;
            if (obs[k] !== e) begin
                bad++;
                $display("FAIL model dut%0d t=%0d got px=%h py=%h fs=%b hs=%b vs=%b de=%b rgb=%h exp px=%h py=%h fs=%b hs=%b vs=%b de=%b rgb=%h",
                         k, t, obs[k].px, obs[k].py, obs[k].fs, obs[k].hs, obs[k].vs, obs[k].de, obs[k].rgb,
                         e.px, e.py, e.fs, e.hs, e.vs, e.de, e.rgb);
            end
        end
        // Default instance: every completed hsync pulse must sit at 656+2 within its line and last 96 clocks.
        if (obs[0].hs == 1'b0) begin
            if (hs_run == 0) hs_start = t;
            hs_run++;
        end else if (hs_run > 0) begin
            total++;
            if (((hs_start - 2) % 800) != 656 || hs_run != 96) begin
                bad++;
                $display("FAIL hsync_pulse got start=%0d len=%0d exp start_mod=656+2 len=96", hs_start, hs_run);
            end
            hs_run = 0;
        end
        // Small instance: whole-frame totals between frame_start pulses.
        if (obs[1].fs) begin
            if (fr_valid) begin
                total++;
                if (fr_cyc != S_FRAME || fr_de != S_HV * S_VV || fr_vs != S_VS * S_HT) begin
                    bad++;
                    $display("FAIL frame_totals got period=%0d de=%0d vs_low=%0d exp period=%0d de=%0d vs_low=%0d",
                             fr_cyc, fr_de, fr_vs, S_FRAME, S_HV * S_VV, S_VS * S_HT);
                end
            end
            fr_valid = 1'b1;
            fr_cyc = 0; fr_de = 0; fr_vs = 0;
        end
        fr_cyc++;
        fr_de += int'(obs[1].de);
        fr_vs += int'(!obs[1].vs);
    endtask

    task automatic drive_step(input bit rnext);
        logic [23:0] pd [2];
        for (int k = 0; k < 2; k++) begin
            pd[k] = echo ? {4'h0, px_prev[k], py_prev[k]} : 24'($urandom);
            pd_last[k] = pd[k];
            px_prev[k] = obs[k].px;
            py_prev[k] = obs[k].py;
        end
        vd.pos_data = pd[0];
        vs_if.pos_data = pd[1];
        tp_last = tp;
        rst = rnext;
        @(posedge clk);
        if (rnext) begin
            t = 0;
            hs_run = 0;
            fr_valid = 1'b0;
        end else begin
            t++;
        end
        sample();
    endtask

    vec_t tbl [15];

    initial begin
        int idx;
        int n;
        tbl[0]  = '{0,   10'd0,   10'd0,   1'b1, 1'b0, 1'b1, 24'h0};
        tbl[1]  = '{1,   10'd1,   10'd0,   1'b0, 1'b0, 1'b1, 24'h0};
        tbl[2]  = '{2,   10'd2,   10'd0,   1'b0, 1'b1, 1'b1, 24'h0};
        tbl[3]  = '{639, 10'd639, 10'd0,   1'b0, 1'b1, 1'b1, 24'h09F400};
        tbl[4]  = '{640, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b1, 24'h09F800};
        tbl[5]  = '{641, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b1, 24'h09FC00};
        tbl[6]  = '{642, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[7]  = '{657, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[8]  = '{658, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 24'h0};
        tbl[9]  = '{753, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 24'h0};
        tbl[10] = '{754, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[11] = '{799, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[12] = '{800, 10'd0,   10'd1,   1'b0, 1'b0, 1'b1, 24'h0};
        tbl[13] = '{801, 10'd1,   10'd1,   1'b0, 1'b0, 1'b1, 24'h0};
        tbl[14] = '{802, 10'd2,   10'd1,   1'b0, 1'b1, 1'b1, 24'h000001};

        for (int k = 0; k < 2; k++) begin
            px_prev[k] = '0; py_prev[k] = '0; pd_last[k] = '0;
        end
        vd.pos_data = '0;
        vs_if.pos_data = '0;

        // Five reset edges, then release with coordinate echo on pos_data.
        @(posedge clk);
        t = 0;
        sample();
        repeat (4) drive_step(1'b1);

        idx = 0;
        while (t < 1700) begin
            if (idx < 15 && t == tbl[idx].t) begin
                hchk($sformatf("vec%0d", idx),
                     {obs[0].px, obs[0].py, obs[0].fs, obs[0].de, obs[0].hs, 1'b0},
                     {tbl[idx].px, tbl[idx].py, tbl[idx].fs, tbl[idx].de, tbl[idx].hs, 1'b0});
                hchk($sformatf("vec%0d_rgb", idx), 32'(obs[0].rgb), 32'(tbl[idx].rgb));
                idx++;
            end
            drive_step(1'b0);
        end
        hchk("vec_all_applied", 32'(idx), 32'd15);

        // One-clock reset at small-instance (h=10, v=5).
        n = 0;
        while ((t % S_FRAME) != 5 * S_HT + 10 && n < 2 * S_FRAME) begin
            drive_step(1'b0);
            n++;
        end
        hchk("midrst_pre_pos", {22'h0, obs[1].px}, 32'd10);
        drive_step(1'b1);
        hchk("midrst_pos", {12'h0, obs[1].px, obs[1].py}, 32'h0);
        hchk("midrst_de0", 32'(obs[1].de), 32'd0);
        drive_step(1'b0);
        hchk("midrst_de1", 32'(obs[1].de), 32'd0);
        drive_step(1'b0);
        hchk("midrst_de2", 32'(obs[1].de), 32'd1);

        // Random pixel data with occasional short resets.
        echo = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 599) == 0) begin
                n = $urandom_range(1, 3);
                repeat (n) drive_step(1'b1);
            end else begin
                drive_step(1'b0);
            end
        end

`ifdef VGA_COLORBAR_EN
        tp = 1'b1;
        repeat (2000) drive_step(1'b0);
        tp = 1'b0;
        repeat (400) drive_step(1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
